// File: rtl/mul_err_sweeper.sv
// ---------------------------------------------------------------------------
// mul_err_sweeper
//
// Exhaustive error evaluator for a 2x2-bit approximate multiplier netlist.
// It walks all 16 input vectors through the external combinational
// multiplier, compares each response with the exact product, and keeps
// three results: the worst absolute error, the number of erroneous vectors
// and the first vector that reached the worst error. At the end of the
// sweep it reports pass/fail against the error threshold ET.
//
// Parameters
//   ET         error threshold, 0..15; pass when max_err <= ET
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous, active-low reset
//   start      in   1  sweep request, only sampled while idle
//   dut_in     out  4  vector to the multiplier, dut_in[k] drives in_k
//   dut_out    in   4  multiplier response, out0 is the LSB
//   busy       out  1  high while the sweep is running
//   done       out  1  one-cycle pulse when the results become valid
//   pass       out  1  max_err <= ET, held until the next accepted start
//   max_err    out  4  maximum absolute error over the sweep
//   err_count  out  5  number of vectors with a nonzero error, 0..16
//   worst_vec  out  4  first vector at which max_err was reached
// ---------------------------------------------------------------------------
module mul_err_sweeper #(
  parameter int ET = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] dut_in,
  input  logic [3:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] max_err,
  output logic [4:0] err_count,
  output logic [3:0] worst_vec
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ET_L = 4'(ET);

  state_t      r_state;
  state_t      w_next_state;

  logic [3:0]  r_dut_in;
  logic [3:0]  r_max_err;
  logic [4:0]  r_err_count;
  logic [3:0]  r_worst_vec;
  logic        r_pass;

  logic [1:0]  w_a;
  logic [1:0]  w_b;
  logic [3:0]  w_exact;
  logic [3:0]  w_err;
  logic        w_err_gt;
  logic [3:0]  w_next_max;
  logic        w_last;

  // Error of the vector currently on dut_in. Subtracting the smaller value
  // from the larger one keeps the magnitude inside 4 bits, which is the
  // same result as a 5-bit absolute difference truncated to 4 bits.
  always_comb begin
    w_a     = r_dut_in[1:0];
    w_b     = r_dut_in[3:2];
    w_exact = {2'b00, w_a} * {2'b00, w_b};
    if (dut_out >= w_exact) begin
      w_err = dut_out - w_exact;
    end else begin
      w_err = w_exact - dut_out;
    end
    // Strict comparison so that ties keep the earliest vector.
    w_err_gt   = (w_err > r_max_err);
    w_next_max = w_err_gt ? w_err : r_max_err;
    w_last     = (r_dut_in == 4'hF);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one pass over the 16 vectors, then a single DONE cycle.
  // A start seen during SWEEP or DONE is simply dropped.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SWEEP;
      SWEEP:   if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Vector counter and result accumulators. Results are cleared only when a
  // start is accepted, so they stay readable in IDLE after a sweep. pass is
  // resolved on the edge that processes the last vector, using the max that
  // edge is about to load, so it is already valid in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dut_in    <= 4'd0;
      r_max_err   <= 4'd0;
      r_err_count <= 5'd0;
      r_worst_vec <= 4'd0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_dut_in <= 4'd0;
          if (start) begin
            r_max_err   <= 4'd0;
            r_err_count <= 5'd0;
            r_worst_vec <= 4'd0;
            r_pass      <= 1'b0;
          end
        end
        SWEEP: begin
          if (w_err_gt) begin
            r_max_err   <= w_err;
            r_worst_vec <= r_dut_in;
          end
          if (w_err != 4'd0) begin
            r_err_count <= r_err_count + 5'd1;
          end
          r_dut_in <= r_dut_in + 4'd1;
          if (w_last) begin
            r_pass <= (w_next_max <= ET_L);
          end
        end
        DONE: begin
          r_dut_in <= 4'd0;
        end
        default: begin
          r_dut_in <= 4'd0;
        end
      endcase
    end
  end

  assign dut_in    = r_dut_in;
  assign busy      = (r_state == SWEEP);
  assign done      = (r_state == DONE);
  assign pass      = r_pass;
  assign max_err   = r_max_err;
  assign err_count = r_err_count;
  assign worst_vec = r_worst_vec;

endmodule
